// File: rtl/cpu_core_if.sv
// Bus bundle for cpu_core: synchronous memory port plus the valid/ready output stream.
// The CPU is the master; board RAM and the UART/debug bridge sit on the slave side.
interface cpu_core_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = DATA_WIDTH - 4
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd;
   logic                  mem_wr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      output mem_addr, mem_rd, mem_wr, mem_wdata, out_valid, out_data,
      input  mem_rdata, out_ready
   );

   modport slave (
      input  mem_addr, mem_rd, mem_wr, mem_wdata, out_valid, out_data,
      output mem_rdata, out_ready
   );
endinterface

// File: rtl/cpu_core.sv
// Multi-cycle accumulator CPU with external synchronous memory and a valid/ready output port.
// Define CPU_CORE_MUL_EN to build the half-word multiplier for opcode A; otherwise it runs as NOP.
module cpu_core #(
   parameter int DATA_WIDTH = 8,
   parameter int OPC_WIDTH  = 4,
   parameter int ADDR_WIDTH = DATA_WIDTH - 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   cpu_core_if.master            bus,
   output logic                  halted,
   output logic [DATA_WIDTH-1:0] acc
);
   localparam int SHW  = $clog2(DATA_WIDTH);
   localparam int HALF = DATA_WIDTH / 2;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, OUTW, HALT} state_t;
   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_OUT, OP_JMP, OP_LDI,
      OP_JC, OP_SHL, OP_MUL, OP_JZ, OP_AND, OP_OR, OP_XOR, OP_HLT
   } opcode_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] ir;
   logic [DATA_WIDTH-1:0] a;
   logic                  c;
   logic                  z;
   logic                  out_valid_q;

   opcode_t               opc;
   logic [ADDR_WIDTH-1:0] operand;
   logic [SHW-1:0]        sh_amt;
   logic [DATA_WIDTH:0]   add_res;
   logic [DATA_WIDTH:0]   shl_res;
   logic [DATA_WIDTH-1:0] ext_operand;
   logic [DATA_WIDTH-1:0] wb_res;
   logic                  is_load;
   logic                  rd_strobe;
   logic                  wr_strobe;
   logic [ADDR_WIDTH-1:0] addr_mux;

   assign opc         = opcode_t'(ir[DATA_WIDTH-1 -: OPC_WIDTH]);
   assign operand     = ir[ADDR_WIDTH-1:0];
   assign sh_amt      = operand[SHW-1:0];
   assign ext_operand = DATA_WIDTH'(operand);
   assign add_res     = {1'b0, a} + {1'b0, bus.mem_rdata};
   // The extra top bit catches the last bit shifted out; a zero shift leaves it clear.
   assign shl_res     = {1'b0, a} << sh_amt;
   assign is_load     = opc inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};

`ifdef CPU_CORE_MUL_EN
   logic [DATA_WIDTH-1:0] mul_res;
   assign mul_res = DATA_WIDTH'(a[HALF-1:0]) * DATA_WIDTH'(a[DATA_WIDTH-1:HALF]);
`endif

   always_comb begin
      wb_res = bus.mem_rdata;
      case (opc)
         OP_ADD:  wb_res = add_res[DATA_WIDTH-1:0];
         OP_SUB:  wb_res = a - bus.mem_rdata;
         OP_AND:  wb_res = a & bus.mem_rdata;
         OP_OR:   wb_res = a | bus.mem_rdata;
         OP_XOR:  wb_res = a ^ bus.mem_rdata;
         default: ;
      endcase
   end

   // Strobes are decoded straight from state so memory sees them in the same cycle; reset masks them.
   always_comb begin
      rd_strobe = 1'b0;
      wr_strobe = 1'b0;
      addr_mux  = '0;
      if (rstn) begin
         addr_mux = pc;
         case (state)
            FETCH: rd_strobe = 1'b1;
            EXEC: begin
               addr_mux  = operand;
               rd_strobe = is_load;
               wr_strobe = (opc == OP_STA);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= FETCH;
         pc          <= '0;
         ir          <= '0;
         a           <= '0;
         c           <= 1'b0;
         z           <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            FETCH: state <= DECODE;
            DECODE: begin
               ir    <= bus.mem_rdata;
               pc    <= pc + ADDR_WIDTH'(1);
               state <= EXEC;
            end
            EXEC: begin
               state <= FETCH;
               case (opc)
                  OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state <= WB;
                  OP_OUT: begin
                     out_valid_q <= 1'b1;
                     state       <= OUTW;
                  end
                  OP_JMP: pc <= operand;
                  OP_LDI: begin
                     a <= ext_operand;
                     z <= (ext_operand == '0);
                  end
                  OP_JC: if (c) pc <= operand;
                  OP_SHL: begin
                     a <= shl_res[DATA_WIDTH-1:0];
                     c <= shl_res[DATA_WIDTH];
                     z <= (shl_res[DATA_WIDTH-1:0] == '0);
                  end
`ifdef CPU_CORE_MUL_EN
                  OP_MUL: begin
                     a <= mul_res;
                     c <= 1'b0;
                     z <= (mul_res == '0);
                  end
`endif
                  OP_JZ:  if (z) pc <= operand;
                  OP_HLT: state <= HALT;
                  default: ;
               endcase
            end
            WB: begin
               a     <= wb_res;
               z     <= (wb_res == '0);
               state <= FETCH;
               if (opc == OP_ADD) c <= add_res[DATA_WIDTH];
               if (opc == OP_SUB) c <= (a < bus.mem_rdata);
            end
            OUTW: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= FETCH;
               end
            end
            HALT: ;
            default: state <= FETCH;
         endcase
      end
   end

   assign bus.mem_addr  = addr_mux;
   assign bus.mem_rd    = rd_strobe;
   assign bus.mem_wr    = wr_strobe;
   assign bus.mem_wdata = a;
   assign bus.out_data  = a;
   assign bus.out_valid = out_valid_q & rstn;
   assign halted        = (state == HALT) & rstn;
   assign acc           = a;
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs plus random programs checked against an ISA-level model.
// An 8-bit core carries most scenarios; a 12-bit core covers program-counter wrap.
module tb_cpu_core;
   logic clk = 1'b0;
   logic rstn;
   logic load_req = 1'b0;
   always #5 clk = ~clk;

   cpu_core_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4)) bus8  ();
   cpu_core_if #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) bus12 ();
   logic        halted8, halted12;
   logic [7:0]  acc8;
   logic [11:0] acc12;

   cpu_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut8 (
      .clk(clk), .rstn(rstn), .bus(bus8.master), .halted(halted8), .acc(acc8));
   cpu_core #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) dut12 (
      .clk(clk), .rstn(rstn), .bus(bus12.master), .halted(halted12), .acc(acc12));

   logic [7:0]  prog8  [16];
   logic [11:0] prog12 [256];
   logic [7:0]  mem8   [16];
   logic [11:0] mem12  [256];
   logic        out_prev = 1'b0;
   int          out_pulses = 0;

   // Synchronous RAMs: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (load_req) begin
         mem8  <= prog8;
         mem12 <= prog12;
      end else begin
         if (bus8.mem_wr) mem8[bus8.mem_addr] <= bus8.mem_wdata;
         if (bus8.mem_rd) bus8.mem_rdata <= mem8[bus8.mem_addr];
         if (bus12.mem_rd) bus12.mem_rdata <= mem12[bus12.mem_addr];
      end
      out_prev <= bus8.out_valid;
      if (bus8.out_valid && !out_prev) out_pulses <= out_pulses + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // ISA-level model state
   int m_pc, m_a, m_c, m_z;
   int m_mem [16];
   bit m_halted;
   int e_lat, e_addr, e_wdata;
   bit e_out, e_halt, e_sta;
   int ready_mode;
   int last_out_n;

   function automatic void model_reset();
      m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_halted = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = int'(prog8[i]);
   endfunction

   function automatic void model_exec();
      int ins, opc, opd, mv, sh;
      bit wr_a;
      ins = m_mem[m_pc];
      opc = ins / 16;
      opd = ins % 16;
      mv  = m_mem[opd];
      m_pc = (m_pc + 1) % 16;
      e_lat = 3; e_out = 0; e_halt = 0; e_sta = 0; wr_a = 0;
      case (opc)
         1:  begin m_a = mv; e_lat = 4; wr_a = 1; end
         2:  begin m_c = (m_a + mv > 255) ? 1 : 0; m_a = (m_a + mv) % 256; e_lat = 4; wr_a = 1; end
         3:  begin m_c = (m_a < mv) ? 1 : 0; m_a = (m_a - mv + 256) % 256; e_lat = 4; wr_a = 1; end
         4:  begin e_sta = 1; e_addr = opd; e_wdata = m_a; m_mem[opd] = m_a; end
         5:  e_out = 1;
         6:  m_pc = opd;
         7:  begin m_a = opd; wr_a = 1; end
         8:  if (m_c != 0) m_pc = opd;
         9:  begin
                sh  = opd % 8;
                m_c = (sh == 0) ? 0 : (m_a >> (8 - sh)) % 2;
                m_a = (m_a << sh) % 256;
                wr_a = 1;
             end
`ifdef CPU_CORE_MUL_EN
         10: begin m_a = (m_a % 16) * (m_a / 16); m_c = 0; wr_a = 1; end
`endif
         11: if (m_z != 0) m_pc = opd;
         12: begin m_a = m_a & mv; e_lat = 4; wr_a = 1; end
         13: begin m_a = m_a | mv; e_lat = 4; wr_a = 1; end
         14: begin m_a = m_a ^ mv; e_lat = 4; wr_a = 1; end
         15: e_halt = 1;
         default: ;
      endcase
      if (wr_a) m_z = (m_a == 0) ? 1 : 0;
   endfunction

   task automatic do_reset();
      rstn = 1'b0;
      bus8.out_ready = 1'b0;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      @(negedge clk);
      model_reset();
      rstn = 1'b1;
      #1;
   endtask

   task automatic fill8(input logic [7:0] v);
      for (int i = 0; i < 16; i++) prog8[i] = v;
   endtask

   // Runs one instruction starting from a FETCH cycle and checks it against the model.
   task automatic step8();
      int  old_a, n;
      bit  r, done;
      n_checks++;
      if (bus8.mem_rd !== 1'b1 || bus8.mem_addr !== 4'(m_pc) || bus8.out_valid !== 1'b0 || halted8 !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL fetch: rd=%b addr=%h valid=%b halted=%b, expected rd=1 addr=%h valid=0 halted=0",
                  bus8.mem_rd, bus8.mem_addr, bus8.out_valid, halted8, m_pc);
      end
      old_a = m_a;
      model_exec();
      @(negedge clk);
      if (ready_mode == 1) bus8.out_ready = 1'b1;
      else if (ready_mode == 0) bus8.out_ready = 1'($urandom_range(0, 1));
      else bus8.out_ready = 1'b0;
      @(negedge clk);
      if (e_sta) begin
         n_checks++;
         if (bus8.mem_wr !== 1'b1 || bus8.mem_addr !== 4'(e_addr) || bus8.mem_wdata !== 8'(old_a)) begin
            n_fail++;
            $display("[TB] FAIL sta: wr=%b addr=%h data=%h, expected wr=1 addr=%h data=%h",
                     bus8.mem_wr, bus8.mem_addr, bus8.mem_wdata, e_addr, old_a);
         end
      end
      if (e_halt) begin
         @(negedge clk);
         n_checks++;
         if (halted8 !== 1'b1 || bus8.mem_rd !== 1'b0 || bus8.mem_wr !== 1'b0 || bus8.out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL halt: halted=%b rd=%b wr=%b valid=%b, expected 1 0 0 0",
                     halted8, bus8.mem_rd, bus8.mem_wr, bus8.out_valid);
         end
         m_halted = 1;
         return;
      end
      if (e_out) begin
         @(negedge clk);
         n = 0;
         done = 0;
         while (!done) begin
            n++;
            n_checks++;
            if (bus8.out_valid !== 1'b1 || bus8.out_data !== 8'(m_a)) begin
               n_fail++;
               $display("[TB] FAIL out_hold: valid=%b data=%h in OUTW cycle %0d, expected valid=1 data=%h",
                        bus8.out_valid, bus8.out_data, n, m_a);
            end
            case (ready_mode)
               1:       r = 1'b1;
               2:       r = (n >= 6);
               default: r = (n >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            bus8.out_ready = r;
            @(negedge clk);
            done = r;
         end
         bus8.out_ready = 1'b0;
         last_out_n = n;
      end else begin
         if (e_lat == 4) @(negedge clk);
         @(negedge clk);
      end
      n_checks++;
      if (acc8 !== 8'(m_a)) begin
         n_fail++;
         $display("[TB] FAIL acc: got %h, expected %h", acc8, m_a);
      end
   endtask

   task automatic test_reset();
      fill8(8'hF0);
      rstn = 1'b0;
      bus8.out_ready = 1'b1;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus8.mem_rd !== 1'b0 || bus8.mem_wr !== 1'b0 || bus8.out_valid !== 1'b0 || halted8 !== 1'b0 || acc8 !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_state: rd=%b wr=%b valid=%b halted=%b acc=%h, expected all zero",
                  bus8.mem_rd, bus8.mem_wr, bus8.out_valid, halted8, acc8);
      end
      model_reset();
      rstn = 1'b1;
      #1;
      n_checks++;
      if (bus8.mem_rd !== 1'b1 || bus8.mem_addr !== 4'h0) begin
         n_fail++;
         $display("[TB] FAIL first_fetch: rd=%b addr=%h, expected rd=1 addr=0", bus8.mem_rd, bus8.mem_addr);
      end
      step8();
   endtask

   task automatic test_out_halt();
      int p0;
      fill8(8'hF0);
      prog8[0] = 8'h75; prog8[1] = 8'h50; prog8[2] = 8'hF0;
      ready_mode = 1;
      do_reset();
      p0 = out_pulses;
      repeat (3) step8();
      n_checks++;
      if (out_pulses - p0 != 1 || acc8 !== 8'h05) begin
         n_fail++;
         $display("[TB] FAIL out_pulse: pulses=%0d acc=%h, expected 1 pulse acc=05", out_pulses - p0, acc8);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (halted8 !== 1'b1 || dut8.pc !== 4'd3 || bus8.mem_rd !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL halt_pc: halted=%b pc=%h rd=%b, expected halted=1 pc=3 rd=0", halted8, dut8.pc, bus8.mem_rd);
      end
   endtask

   task automatic test_carry_jump();
      fill8(8'hF0);
      prog8[0] = 8'h18; prog8[1] = 8'h29; prog8[2] = 8'h85; prog8[5] = 8'hB7;
      prog8[8] = 8'hF0; prog8[9] = 8'h20;
      ready_mode = 1;
      do_reset();
      repeat (2) step8();
      n_checks++;
      if (acc8 !== 8'h10) begin
         n_fail++;
         $display("[TB] FAIL add_carry: acc=%h, expected 10", acc8);
      end
      step8();
      n_checks++;
      if (bus8.mem_addr !== 4'h5) begin
         n_fail++;
         $display("[TB] FAIL jc_taken: fetch addr=%h, expected 5", bus8.mem_addr);
      end
      step8();
      n_checks++;
      if (bus8.mem_addr !== 4'h6) begin
         n_fail++;
         $display("[TB] FAIL jz_not_taken: fetch addr=%h, expected 6", bus8.mem_addr);
      end
      step8();
   endtask

   task automatic test_sub();
      fill8(8'hF0);
      prog8[0] = 8'h73; prog8[1] = 8'h38; prog8[2] = 8'hB5; prog8[5] = 8'h87; prog8[8] = 8'h03;
      ready_mode = 1;
      do_reset();
      repeat (2) step8();
      n_checks++;
      if (acc8 !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL sub_zero: acc=%h, expected 00", acc8);
      end
      step8();
      n_checks++;
      if (bus8.mem_addr !== 4'h5) begin
         n_fail++;
         $display("[TB] FAIL jz_taken: fetch addr=%h, expected 5", bus8.mem_addr);
      end
      step8();
      n_checks++;
      if (bus8.mem_addr !== 4'h6) begin
         n_fail++;
         $display("[TB] FAIL sub_no_borrow: fetch addr=%h, expected 6", bus8.mem_addr);
      end
      fill8(8'hF0);
      prog8[0] = 8'h72; prog8[1] = 8'h38; prog8[2] = 8'h84; prog8[4] = 8'hB6; prog8[8] = 8'h05;
      do_reset();
      repeat (2) step8();
      n_checks++;
      if (acc8 !== 8'hFD) begin
         n_fail++;
         $display("[TB] FAIL sub_borrow: acc=%h, expected FD", acc8);
      end
      step8();
      n_checks++;
      if (bus8.mem_addr !== 4'h4) begin
         n_fail++;
         $display("[TB] FAIL borrow_jc: fetch addr=%h, expected 4", bus8.mem_addr);
      end
      step8();
      n_checks++;
      if (bus8.mem_addr !== 4'h5) begin
         n_fail++;
         $display("[TB] FAIL borrow_jz: fetch addr=%h, expected 5", bus8.mem_addr);
      end
   endtask

   task automatic test_shift_mul();
      logic [7:0] exp_mul;
      logic [3:0] exp_jz;
`ifdef CPU_CORE_MUL_EN
      exp_mul = 8'h00; exp_jz = 4'h7;
`else
      exp_mul = 8'h0F; exp_jz = 4'h6;
`endif
      fill8(8'hF0);
      prog8[0] = 8'h73; prog8[1] = 8'h96; prog8[2] = 8'h87; prog8[3] = 8'h7F;
      prog8[4] = 8'hA0; prog8[5] = 8'hB7;
      ready_mode = 1;
      do_reset();
      repeat (2) step8();
      n_checks++;
      if (acc8 !== 8'hC0) begin
         n_fail++;
         $display("[TB] FAIL shl: acc=%h, expected C0", acc8);
      end
      step8();
      n_checks++;
      if (bus8.mem_addr !== 4'h3) begin
         n_fail++;
         $display("[TB] FAIL shl_carry: fetch addr=%h, expected 3", bus8.mem_addr);
      end
      repeat (2) step8();
      n_checks++;
      if (acc8 !== exp_mul) begin
         n_fail++;
         $display("[TB] FAIL mul: acc=%h, expected %h", acc8, exp_mul);
      end
      step8();
      n_checks++;
      if (bus8.mem_addr !== exp_jz) begin
         n_fail++;
         $display("[TB] FAIL mul_zero_flag: fetch addr=%h, expected %h", bus8.mem_addr, exp_jz);
      end
   endtask

   task automatic test_out_backpressure();
      fill8(8'hF0);
      prog8[0] = 8'h7A; prog8[1] = 8'h50;
      ready_mode = 2;
      do_reset();
      repeat (3) step8();
      n_checks++;
      if (last_out_n != 6) begin
         n_fail++;
         $display("[TB] FAIL out_valid_cycles: got %0d, expected 6", last_out_n);
      end
   endtask

   task automatic test_reset_in_outw();
      fill8(8'hF0);
      prog8[0] = 8'h79; prog8[1] = 8'h50;
      ready_mode = 2;
      do_reset();
      step8();
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus8.out_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL outw_entered: valid=%b, expected 1", bus8.out_valid);
      end
      rstn = 1'b0;
      #1;
      n_checks++;
      if (bus8.out_valid !== 1'b0 || bus8.mem_rd !== 1'b0 || bus8.mem_wr !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_drops_valid: valid=%b rd=%b wr=%b, expected 0 0 0",
                  bus8.out_valid, bus8.mem_rd, bus8.mem_wr);
      end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      n_checks++;
      if (bus8.mem_rd !== 1'b1 || bus8.mem_addr !== 4'h0 || bus8.out_valid !== 1'b0 || acc8 !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_pc: rd=%b addr=%h valid=%b acc=%h, expected 1 0 0 00",
                  bus8.mem_rd, bus8.mem_addr, bus8.out_valid, acc8);
      end
      model_reset();
      step8();
   endtask

   task automatic test_wrap12();
      logic [7:0] exp_addr [4];
      exp_addr[0] = 8'h00; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'hFF;
      for (int i = 0; i < 256; i++) prog12[i] = 12'h000;
      prog12[0] = 12'h6FF;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (bus12.mem_rd !== 1'b1 || bus12.mem_addr !== exp_addr[k]) begin
            n_fail++;
            $display("[TB] FAIL pc_wrap: step %0d rd=%b addr=%h, expected rd=1 addr=%h",
                     k, bus12.mem_rd, bus12.mem_addr, exp_addr[k]);
         end
         repeat (3) @(negedge clk);
      end
      prog12[8'hFF] = 12'h6FF;
      do_reset();
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (bus12.mem_rd !== 1'b1 || bus12.mem_addr !== 8'hFF || halted12 !== 1'b0 ||
             bus12.mem_wr !== 1'b0 || bus12.out_valid !== 1'b0 || acc12 !== 12'h000) begin
            n_fail++;
            $display("[TB] FAIL self_jump: rd=%b addr=%h halted=%b wr=%b valid=%b acc=%h, expected 1 FF 0 0 0 000",
                     bus12.mem_rd, bus12.mem_addr, halted12, bus12.mem_wr, bus12.out_valid, acc12);
         end
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic test_random();
      int k;
      for (int p = 0; p < 10; p++) begin
         for (int i = 0; i < 16; i++) prog8[i] = 8'($urandom);
         ready_mode = 0;
         do_reset();
         k = 0;
         while (!m_halted && k < 25) begin
            step8();
            k++;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bus12.out_ready = 1'b0;
      for (int i = 0; i < 256; i++) prog12[i] = 12'h000;
      test_reset();
      test_out_halt();
      test_carry_jump();
      test_sub();
      test_shift_mul();
      test_out_backpressure();
      test_reset_in_outw();
      test_wrap12();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
